// File: rtl/mac_mul_feed_if.sv
// ---------------------------------------------------------------------------
// mac_mul_feed_if
// Operand stream and result stream of the MAC feeder grouped into one bundle.
//   in_valid/in_ready    operand pair stream (in_a, in_b, in_signed,
//                        in_first, in_last)
//   res_valid/res_ready  finished dot product stream (res_data)
// Handshake: a beat transfers on the rising clock edge where valid && ready
// are both high. The producer holds valid and its payload stable until the
// transfer. Ready may depend combinationally on the receiver's state but
// never on valid.
// Modports: master = operand producer / result consumer, slave = feeder.
// ---------------------------------------------------------------------------
interface mac_mul_feed_if #(
    parameter int W = 8,
    parameter int A = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_signed;
    logic         in_first;
    logic         in_last;
    logic         res_valid;
    logic         res_ready;
    logic [A-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_first, in_last, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_first, in_last, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac_mul_feed.sv
// ---------------------------------------------------------------------------
// mac_mul_feed
// Upstream feeder for the MAC accumulator. Operand pairs pass through a
// 2-stage multiply pipeline (S1 registers operands, S2 registers the exact
// product), S2 drives the accumulator controls, and the accumulator's sum is
// captured into a one-entry result buffer once a group's last element has
// been folded in.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        operand stream in, result stream out (mac_mul_feed_if.slave)
//   acc_en     accumulator add enable (acc += acc_in)
//   acc_cset   accumulator load (acc = acc_init)
//   acc_init   load value, 0 when not loading
//   acc_in     addend, 0 when not adding
//   acc_carry  accumulator carry in, constant 0
//   acc_out    accumulator registered sum
// MAC_ACC_WIDTH must be at least 2*MAC_MIN_WIDTH so every product is exact.
// ---------------------------------------------------------------------------
module mac_mul_feed #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    mac_mul_feed_if.slave            bus,
    output logic                     acc_en,
    output logic                     acc_cset,
    output logic [MAC_ACC_WIDTH-1:0] acc_init,
    output logic [MAC_ACC_WIDTH-1:0] acc_in,
    output logic                     acc_carry,
    input  logic [MAC_ACC_WIDTH-1:0] acc_out
);
    localparam int W = MAC_MIN_WIDTH;
    localparam int A = MAC_ACC_WIDTH;

    // S1: registered operands
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;
    logic         r_s1_signed;
    logic         r_s1_first;
    logic         r_s1_last;
    logic         r_s1_v;

    // S2: registered product
    logic [A-1:0] r_s2_prod;
    logic         r_s2_first;
    logic         r_s2_last;
    logic         r_s2_v;

    // Result capture
    logic         r_pend;
    logic         r_res_valid;
    logic [A-1:0] r_res_data;

    logic         w_s2_fire;
    logic         w_s2_take;
    logic         w_s1_adv;
    logic         w_in_ready;
    logic         w_in_fire;
    logic [A-1:0] w_a_ext;
    logic [A-1:0] w_b_ext;
    logic [A-1:0] w_prod;

    // A last element may only fire when the result slot will be free at the
    // capture edge: nothing pending and the buffer empty or draining now.
    assign w_s2_fire  = r_s2_v && (!r_s2_last ||
                        (!r_pend && (!r_res_valid || bus.res_ready)));
    assign w_s2_take  = !r_s2_v || w_s2_fire;
    assign w_s1_adv   = r_s1_v && w_s2_take;
    assign w_in_ready = !r_s1_v || w_s2_take;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    // Extending both operands to A bits makes the low A bits of the product
    // exact for both signed and unsigned operands.
    assign w_a_ext = r_s1_signed ? {{(A-W){r_s1_a[W-1]}}, r_s1_a}
                                 : {{(A-W){1'b0}}, r_s1_a};
    assign w_b_ext = r_s1_signed ? {{(A-W){r_s1_b[W-1]}}, r_s1_b}
                                 : {{(A-W){1'b0}}, r_s1_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_signed <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_v      <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_a      <= bus.in_a;
            r_s1_b      <= bus.in_b;
            r_s1_signed <= bus.in_signed;
            r_s1_first  <= bus.in_first;
            r_s1_last   <= bus.in_last;
            r_s1_v      <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_v      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_prod  <= '0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_v     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_prod  <= w_prod;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_v     <= 1'b1;
        end else if (w_s2_fire) begin
            r_s2_v     <= 1'b0;
        end
    end

    // The accumulator updates at the edge ending the fire cycle; its out is
    // therefore sampled one edge later. A new group's element firing in that
    // gap does not disturb the captured value because acc_out is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_pend <= w_s2_fire && r_s2_last;
            if (r_pend) begin
                r_res_data  <= acc_out;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        acc_en   = 1'b0;
        acc_cset = 1'b0;
        acc_init = '0;
        acc_in   = '0;
        if (w_s2_fire) begin
            if (r_s2_first) begin
                acc_cset = 1'b1;
                acc_init = r_s2_prod;
            end else begin
                acc_en   = 1'b1;
                acc_in   = r_s2_prod;
            end
        end
    end

    assign acc_carry     = 1'b0;
    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
endmodule

// File: tb/tb_mac_mul_feed.sv
module tb_mac_mul_feed;
    localparam int W = 8;
    localparam int A = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_mul_feed_if #(.W(W), .A(A)) bus ();

    logic         acc_en;
    logic         acc_cset;
    logic [A-1:0] acc_init;
    logic [A-1:0] acc_in;
    logic         acc_carry;
    logic [A-1:0] acc_out;

    mac_mul_feed #(.MAC_MIN_WIDTH(W), .MAC_ACC_WIDTH(A)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .acc_en    (acc_en),
        .acc_cset  (acc_cset),
        .acc_init  (acc_init),
        .acc_in    (acc_in),
        .acc_carry (acc_carry),
        .acc_out   (acc_out)
    );

    // Behavioural accumulator the feeder talks to (not reset by the feeder).
    logic [A-1:0] acc_q = '0;
    assign acc_out = acc_q;
    always @(posedge clk) begin
        if (acc_cset) acc_q <= acc_init;
        else if (acc_en) acc_q <= acc_q + acc_in + {{(A-1){1'b0}}, acc_carry};
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_fire   = 0;
    int last_accept_edge = 0;
    int rise_edge = 0;
    bit prev_rv  = 1'b0;
    bit cont_phase = 1'b0;
    logic [A-1:0] exp_q[$];
    logic [A-1:0] fire_q[$];
    bit           fire_first_q[$];
    logic [A-1:0] res_hist[$];
    logic [A-1:0] run_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [A-1:0] act, logic [A-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    function automatic logic [A-1:0] model_prod(logic [W-1:0] a, logic [W-1:0] b, bit s);
        longint sa;
        longint sb;
        longint p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[A-1:0];
    endfunction

    function automatic logic [A-1:0] res_back(int k);
        if (res_hist.size() < k + 1) return 'x;
        return res_hist[res_hist.size() - 1 - k];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            logic [A-1:0] p;
            bit           f;
            check("acc_carry", {{(A-1){1'b0}}, acc_carry}, '0);
            if (acc_en || acc_cset) begin
                n_fire++;
                if (fire_q.size() == 0) begin
                    check("fire_unexpected", {{(A-2){1'b0}}, acc_cset, acc_en}, '0);
                end else begin
                    p = fire_q.pop_front();
                    f = fire_first_q.pop_front();
                    check("fire_kind", {{(A-2){1'b0}}, acc_cset, acc_en}, f ? 2 : 1);
                    check("fire_value", acc_cset ? acc_init : acc_in, p);
                    check("fire_other_zero", acc_cset ? acc_in : acc_init, '0);
                end
            end else begin
                check("acc_idle_zero", acc_init | acc_in, '0);
            end
            if (cont_phase) check("cont_in_ready", {{(A-1){1'b0}}, bus.in_ready}, 1);
            if (bus.in_valid && bus.in_ready) begin
                p = model_prod(bus.in_a, bus.in_b, bus.in_signed);
                fire_q.push_back(p);
                fire_first_q.push_back(bus.in_first);
                run_sum = bus.in_first ? p : run_sum + p;
                if (bus.in_last) exp_q.push_back(run_sum);
                last_accept_edge = cyc + 1;
            end
            if (bus.res_valid && !prev_rv) rise_edge = cyc;
            prev_rv = bus.res_valid;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", {{(A-1){1'b0}}, bus.res_valid}, '0);
                end else begin
                    check("res_data", bus.res_data, exp_q.pop_front());
                end
                res_hist.push_back(bus.res_data);
            end
        end else begin
            prev_rv = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(logic [W-1:0] a, logic [W-1:0] b, bit s, bit f, bit l);
        int  t;
        bit  rdy;
        t = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_first  = f;
        bus.in_last   = l;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 300) begin
                check("send_timeout", t, 0);
                break;
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_a      = W'($urandom);
        bus.in_b      = W'($urandom);
        bus.in_first  = 1'($urandom);
        bus.in_last   = 1'($urandom);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fire_q.size() != 0) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        idle(2);
        check("drain", exp_q.size() + fire_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    bit rr_run;

    initial begin
        int f0;
        int elems;
        int len;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b1;

        // Reset state
        #2;
        check("rst_res_valid", {{(A-1){1'b0}}, bus.res_valid}, '0);
        check("rst_res_data", bus.res_data, '0);
        check("rst_acc_ctl", {{(A-2){1'b0}}, acc_en, acc_cset}, '0);
        check("rst_acc_data", acc_init | acc_in, '0);
        check("rst_in_ready", {{(A-1){1'b0}}, bus.in_ready}, 1);
        idle(2);
        rst = 1'b1;
        idle(1);

        // Unsigned 3-element dot product and its latency
        send(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        send(8'd4, 8'd5, 1'b0, 1'b0, 1'b0);
        send(8'd6, 8'd7, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("t_unsigned_68", res_back(0), 32'd68);
        check("t_latency", rise_edge - last_accept_edge, 3);

        // Signed and unsigned extremes
        send(8'hFD, 8'd5, 1'b1, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
        send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("t_signed_16369", res_back(1), 32'd16369);
        check("t_unsigned_65025", res_back(0), 32'd65025);

        // Back-pressure on the result buffer
        bus.res_ready = 1'b0;
        send(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
        send(8'd1, 8'd2, 1'b0, 1'b0, 1'b1);
        send(8'd3, 8'd3, 1'b0, 1'b1, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0, 1'b1);
        idle(6);
        send(8'd5, 8'd5, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("bp_in_ready_low", {{(A-1){1'b0}}, bus.in_ready}, '0);
        check("bp_res_valid", {{(A-1){1'b0}}, bus.res_valid}, 1);
        check("bp_held_3", bus.res_data, 32'd3);
        bus.res_ready = 1'b1;
        idle(1);
        bus.res_ready = 1'b0;
        idle(6);
        check("bp_second_21", bus.res_data, 32'd21);
        bus.res_ready = 1'b1;
        wait_drain();
        check("bp_hist_3", res_back(2), 32'd3);
        check("bp_hist_21", res_back(1), 32'd21);
        check("bp_hist_25", res_back(0), 32'd25);

        // Continuous stream, groups of 2..4 elements
        f0 = n_fire;
        elems = 0;
        cont_phase = 1'b1;
        for (int g = 0; g < 8; g++) begin
            bit s;
            len = $urandom_range(2, 4);
            s = 1'($urandom);
            for (int e = 0; e < len; e++) begin
                send(W'($urandom), W'($urandom), s, e == 0, e == len - 1);
                elems++;
            end
        end
        cont_phase = 1'b0;
        wait_drain();
        check("cont_fire_count", n_fire - f0, elems);

        // Reset with S1, S2 and the result buffer occupied
        bus.res_ready = 1'b0;
        send(8'd1, 8'd10, 1'b0, 1'b1, 1'b1);
        idle(5);
        send(8'd4, 8'd4, 1'b0, 1'b1, 1'b1);
        send(8'd5, 8'd5, 1'b0, 1'b1, 1'b1);
        check("pre_rst_res_valid", {{(A-1){1'b0}}, bus.res_valid}, 1);
        check("pre_rst_in_ready", {{(A-1){1'b0}}, bus.in_ready}, '0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_res_valid", {{(A-1){1'b0}}, bus.res_valid}, '0);
        check("mid_rst_res_data", bus.res_data, '0);
        check("mid_rst_in_ready", {{(A-1){1'b0}}, bus.in_ready}, 1);
        check("mid_rst_acc_ctl", {{(A-2){1'b0}}, acc_en, acc_cset}, '0);
        exp_q.delete();
        fire_q.delete();
        fire_first_q.delete();
        idle(2);
        rst = 1'b1;
        bus.res_ready = 1'b1;
        idle(1);
        send(8'd7, 8'd6, 1'b0, 1'b1, 1'b1);
        wait_drain();
        check("post_rst_42", res_back(0), 32'd42);

        // Group without first continues onto the held sum
        send(8'd1, 8'd10, 1'b0, 1'b1, 1'b1);
        send(8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
        wait_drain();
        check("nofirst_10", res_back(1), 32'd10);
        check("nofirst_14", res_back(0), 32'd14);

        // Randomized traffic with random result back-pressure
        rr_run = 1'b1;
        fork
            begin
                while (rr_run) begin
                    @(posedge clk);
                    #1;
                    bus.res_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int g = 0; g < 40; g++) begin
                    bit s;
                    bit cont;
                    len  = $urandom_range(1, 4);
                    s    = 1'($urandom);
                    cont = ($urandom_range(0, 9) == 0);
                    for (int e = 0; e < len; e++) begin
                        send(W'($urandom), W'($urandom), s, (e == 0) && !cont, e == len - 1);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                rr_run = 1'b0;
            end
        join
        bus.res_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
